// File: rtl/bkram_sd_seq_if.sv
// Sector-transfer handshake between the backup-RAM sequencer and the HPS SD block.
interface bkram_sd_seq_if;
  logic [31:0] sd_lba;
  logic        sd_rd;
  logic        sd_wr;
  logic        sd_ack;

  modport master (output sd_lba, output sd_rd, output sd_wr, input sd_ack);
  modport slave  (input sd_lba, input sd_rd, input sd_wr, output sd_ack);
endinterface

// File: rtl/bkram_sd_seq.sv
// Backup-RAM load/save sequencer: walks sd_lba over the save image one sector
// per HPS ack, with autoload after ROM download and an ack-timeout escape.
module bkram_sd_seq #(
  parameter logic [23:0] ACK_TIMEOUT = 24'd16777215
) (
  input  logic                 clk_sys,
  input  logic                 RESET,
  input  logic                 ioctl_download,
  input  logic                 img_mounted,
  input  logic                 img_readonly,
  input  logic [63:0]          img_size,
  input  logic                 bk_load,
  input  logic                 bk_save,
  input  logic [23:0]          ram_mask,
  bkram_sd_seq_if.master       sd,
  output logic                 bk_ena,
  output logic                 bk_loading,
  output logic                 bk_busy,
  output logic                 bk_err
);

  typedef enum logic [1:0] {IDLE, REQ, XFER, NEXT} state_t;

  state_t      state, state_n;
  logic [31:0] lba, lba_n;
  logic [23:0] cnt, cnt_n;
  logic        rd, rd_n, wr, wr_n;
  logic        loading, loading_n, busy, busy_n, err, err_n;
  logic        op_load, op_load_n;

  logic        dl_q, load_q, save_q, ack_q;
  logic        load_lvl, save_lvl;
  logic        dl_rise, dl_fall, load_rise, save_rise, ack_fall;
  logic        start_load, start, last_sector, ena_set;

  always_comb begin
    load_lvl    = bk_load & bk_ena;
    save_lvl    = bk_save & bk_ena;
    dl_rise     = ioctl_download & ~dl_q;
    dl_fall     = ~ioctl_download & dl_q;
    load_rise   = load_lvl & ~load_q;
    save_rise   = save_lvl & ~save_q;
    ack_fall    = ~sd.sd_ack & ack_q;
    // autoload outranks OSD edges, and load outranks save
    start_load  = (dl_fall & bk_ena) | load_rise;
    start       = start_load | save_rise;
    last_sector = lba >= 32'(ram_mask >> 9);
    ena_set     = ioctl_download & img_mounted & (|img_size) & ~img_readonly;
  end

  always_comb begin
    state_n   = state;
    lba_n     = lba;
    cnt_n     = cnt;
    rd_n      = rd;
    wr_n      = wr;
    loading_n = loading;
    busy_n    = busy;
    err_n     = err;
    op_load_n = op_load;
    unique case (state)
      IDLE: begin
        if (start) begin
          lba_n     = '0;
          cnt_n     = '0;
          op_load_n = start_load;
          loading_n = start_load;
          busy_n    = 1'b1;
          err_n     = 1'b0;
          rd_n      = start_load;
          wr_n      = ~start_load;
          state_n   = REQ;
        end
      end
      REQ: begin
        if (sd.sd_ack) begin
          rd_n    = 1'b0;
          wr_n    = 1'b0;
          state_n = XFER;
        end else if (cnt == ACK_TIMEOUT - 24'd1) begin
          rd_n      = 1'b0;
          wr_n      = 1'b0;
          err_n     = 1'b1;
          loading_n = 1'b0;
          busy_n    = 1'b0;
          state_n   = IDLE;
        end else begin
          cnt_n = cnt + 24'd1;
        end
      end
      XFER: begin
        if (ack_fall) state_n = NEXT;
      end
      NEXT: begin
        if (last_sector) begin
          loading_n = 1'b0;
          busy_n    = 1'b0;
          state_n   = IDLE;
        end else begin
          lba_n   = lba + 32'd1;
          cnt_n   = '0;
          rd_n    = op_load;
          wr_n    = ~op_load;
          state_n = REQ;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (RESET) begin
      state   <= IDLE;
      lba     <= '0;
      cnt     <= '0;
      rd      <= 1'b0;
      wr      <= 1'b0;
      loading <= 1'b0;
      busy    <= 1'b0;
      err     <= 1'b0;
      op_load <= 1'b0;
      bk_ena  <= 1'b0;
    end else begin
      state   <= state_n;
      lba     <= lba_n;
      cnt     <= cnt_n;
      rd      <= rd_n;
      wr      <= wr_n;
      loading <= loading_n;
      busy    <= busy_n;
      err     <= err_n;
      op_load <= op_load_n;
      if (dl_rise) bk_ena <= 1'b0;
      if (ena_set) bk_ena <= 1'b1;
    end
  end

  // Edge detectors track inputs during reset too, so nothing fires right after it.
  always_ff @(posedge clk_sys) begin
    if (RESET) begin
      dl_q   <= ioctl_download;
      load_q <= bk_load;
      save_q <= bk_save;
      ack_q  <= sd.sd_ack;
    end else begin
      dl_q   <= ioctl_download;
      load_q <= load_lvl;
      save_q <= save_lvl;
      ack_q  <= sd.sd_ack;
    end
  end

  assign sd.sd_lba  = lba;
  assign sd.sd_rd   = rd;
  assign sd.sd_wr   = wr;
  assign bk_loading = loading;
  assign bk_busy    = busy;
  assign bk_err     = err;

endmodule
